// File: rtl/delay_sched_pkg.sv
// Shared types and helpers for the delay_scheduler timer-sharing block.
package delay_sched_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int ptr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/delay_scheduler_rr_pick.sv
// Combinational round-robin selector: first set req bit at or above ptr, wrapping.
module rr_pick
    import delay_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] win,
    output logic [PTR_W-1:0] win_idx
);

    logic found;
    int   idx;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                win[idx] = 1'b1;
                win_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/delay_scheduler.sv
// One programmable delay counter shared round-robin among N_REQ requesters.
// Optional: define DELAY_SCHED_ABORT_EN to let an owner cancel by dropping req.
module delay_scheduler
    import delay_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int BITS  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*BITS-1:0]   delay,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        done,
    output logic                    busy
);

    localparam int PTR_W = ptr_width(N_REQ);

    state_t           state, state_nxt;
    logic [PTR_W-1:0] ptr, owner, win_idx, ptr_adv;
    logic [N_REQ-1:0] win;
    logic [BITS-1:0]  count, final_q;
    logic             expire, abort;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req     (req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx)
    );

`ifdef DELAY_SCHED_ABORT_EN
    assign abort = ~req[owner];
`else
    assign abort = 1'b0;
`endif

    assign expire  = tick && (count == final_q);
    assign ptr_adv = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE) ? grant : '0;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = LOAD;
            LOAD:    state_nxt = abort ? IDLE : RUN;
            RUN: begin
                if (abort)       state_nxt = IDLE;
                else if (expire) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant/owner capture, counter and pointer update follow the FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant   <= '0;
            owner   <= '0;
            ptr     <= '0;
            count   <= '0;
            final_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant <= win;
                        owner <= win_idx;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        grant <= '0;
                        ptr   <= ptr_adv;
                    end else begin
                        final_q <= delay[owner*BITS +: BITS];
                        count   <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        grant <= '0;
                        ptr   <= ptr_adv;
                    end else if (tick && !expire) begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    grant <= '0;
                    ptr   <= ptr_adv;
                end
                default: ;
            endcase
        end
    end

endmodule
